// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
// Purely declarative: no timing or flow control of its own.
package pipe_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      DIV_WAIT = 1'b1
   } ctrl_state_t;

   localparam int REG_W = 5;

   localparam int STG_F   = 0;
   localparam int STG_D   = 1;
   localparam int STG_E   = 2;
   localparam int STG_M   = 3;
   localparam int STG_W   = 4;
   localparam int NUM_STG = 5;

   // Register $0 is hardwired, so a producer writing it never creates a hazard.
   function automatic logic srcMatch(input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] srcA,
                                     input logic [REG_W-1:0] srcB);
      return (dst != '0) && ((dst == srcA) || (dst == srcB));
   endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use compare of the D-stage sources against loads sitting in E and M.
// Purely combinational, zero latency, no flow control.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic [REG_W-1:0] rsD,
   input  logic [REG_W-1:0] rtD,
   input  logic             mem_to_regE,
   input  logic             reg_write_enE,
   input  logic [REG_W-1:0] write_regE,
   input  logic             mem_to_regM,
   input  logic [REG_W-1:0] write_regM,
   output logic             luHazard
);

   logic hitE;
   logic hitM;

   assign hitE     = mem_to_regE & reg_write_enE & srcMatch(write_regE, rsD, rtD);
   assign hitM     = mem_to_regM & srcMatch(write_regM, rsD, rtD);
   assign luHazard = hitE | hitM;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush scheduler for the five-stage core; outputs are combinational (zero latency).
// Flushes seen during a cache stall are held and applied once in the first unstalled cycle.
module pipe_ctrl
   import pipe_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] rsD,
   input  logic [REG_W-1:0] rtD,
   input  logic             mem_to_regE,
   input  logic             reg_write_enE,
   input  logic [REG_W-1:0] write_regE,
   input  logic             mem_to_regM,
   input  logic [REG_W-1:0] write_regM,
   input  logic             div_startE,
   input  logic             div_doneE,
   input  logic             i_stall,
   input  logic             d_stall,
   input  logic             exceptionM,
   input  logic             mispredictE,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             stallM,
   output logic             stallW,
   output logic             flushD,
   output logic             flushE,
   output logic             flushM,
   output logic             flushW,
   output logic             div_cancel,
   output logic             div_busy
);

   ctrl_state_t            state;
   ctrl_state_t            stateNxt;
   logic                   excPend;
   logic                   excPendNxt;
   logic                   mpPend;
   logic                   mpPendNxt;
   logic [NUM_STG-1:0]     stallVec;
   logic [STG_W:STG_D]     flushVec;
   logic                   divCancel;
   logic                   gstall;
   logic                   exc;
   logic                   lu;
   logic                   dstall;

   hazard_detect uHazard (
      .rsD           (rsD),
      .rtD           (rtD),
      .mem_to_regE   (mem_to_regE),
      .reg_write_enE (reg_write_enE),
      .write_regE    (write_regE),
      .mem_to_regM   (mem_to_regM),
      .write_regM    (write_regM),
      .luHazard      (lu)
   );

   assign gstall = i_stall | d_stall;
   assign exc    = exceptionM | excPend;
   assign dstall = ((state == RUN) & div_startE) | ((state == DIV_WAIT) & ~div_doneE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= RUN;
         excPend <= 1'b0;
         mpPend  <= 1'b0;
      end else begin
         state   <= stateNxt;
         excPend <= excPendNxt;
         mpPend  <= mpPendNxt;
      end
   end

   always_comb begin
      stallVec   = '0;
      flushVec   = '0;
      divCancel  = 1'b0;
      stateNxt   = state;
      excPendNxt = excPend;
      mpPendNxt  = mpPend;

      if (exc && !gstall) begin
         flushVec   = '1;
         divCancel  = (state == DIV_WAIT) | div_startE;
         stateNxt   = RUN;
         excPendNxt = 1'b0;
         mpPendNxt  = 1'b0;
      end else if (gstall) begin
         stallVec = '1;
         if (exceptionM)  excPendNxt = 1'b1;
         if (mispredictE) mpPendNxt  = 1'b1;
         // The divider keeps running under a cache stall, so a completion is not lost.
         if ((state == DIV_WAIT) && div_doneE) stateNxt = RUN;
      end else if (dstall) begin
         stallVec[STG_F] = 1'b1;
         stallVec[STG_D] = 1'b1;
         stallVec[STG_E] = 1'b1;
         flushVec[STG_M] = 1'b1;
         if (state == RUN) stateNxt  = DIV_WAIT;
         if (mispredictE)  mpPendNxt = 1'b1;
      end else begin
         // Not dstall here, so a DIV_WAIT state means div_doneE is high this cycle.
         stateNxt = RUN;
         if (lu) begin
            stallVec[STG_F] = 1'b1;
            stallVec[STG_D] = 1'b1;
            flushVec[STG_E] = 1'b1;
            if (mispredictE) mpPendNxt = 1'b1;
         end else if (mispredictE || mpPend) begin
            flushVec[STG_D] = 1'b1;
            mpPendNxt       = 1'b0;
         end
      end
   end

   assign stallF     = stallVec[STG_F];
   assign stallD     = stallVec[STG_D];
   assign stallE     = stallVec[STG_E];
   assign stallM     = stallVec[STG_M];
   assign stallW     = stallVec[STG_W];
   assign flushD     = flushVec[STG_D];
   assign flushE     = flushVec[STG_E];
   assign flushM     = flushVec[STG_M];
   assign flushW     = flushVec[STG_W];
   assign div_cancel = divCancel;
   assign div_busy   = (state == DIV_WAIT);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scenarios plus randomized traffic against a priority-table reference model.
module tb_pipe_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rsD, rtD, write_regE, write_regM;
   logic       mem_to_regE, reg_write_enE, mem_to_regM;
   logic       div_startE, div_doneE, i_stall, d_stall, exceptionM, mispredictE;
   logic       stallF, stallD, stallE, stallM, stallW;
   logic       flushD, flushE, flushM, flushW, div_cancel, div_busy;

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk(clk), .rst(rst),
      .rsD(rsD), .rtD(rtD),
      .mem_to_regE(mem_to_regE), .reg_write_enE(reg_write_enE), .write_regE(write_regE),
      .mem_to_regM(mem_to_regM), .write_regM(write_regM),
      .div_startE(div_startE), .div_doneE(div_doneE),
      .i_stall(i_stall), .d_stall(d_stall),
      .exceptionM(exceptionM), .mispredictE(mispredictE),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
      .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
      .div_cancel(div_cancel), .div_busy(div_busy)
   );

   int nTests = 0;
   int nFail  = 0;

   // Reference model state: a divide is outstanding, a flush is owed.
   bit mBusy, mExcOwed, mMpOwed;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [10:0] obs();
      return {stallF, stallD, stallE, stallM, stallW,
              flushD, flushE, flushM, flushW, div_cancel, div_busy};
   endfunction

   function automatic bit luRef();
      logic [4:0] dst[2];
      bit         isLoad[2];
      dst[0] = write_regE;  isLoad[0] = mem_to_regE && reg_write_enE;
      dst[1] = write_regM;  isLoad[1] = mem_to_regM;
      foreach (dst[i])
         if (isLoad[i] && dst[i] != 5'd0 && (dst[i] == rsD || dst[i] == rtD)) return 1'b1;
      return 1'b0;
   endfunction

   task automatic clearInputs();
      rsD = 0; rtD = 0; write_regE = 0; write_regM = 0;
      mem_to_regE = 0; reg_write_enE = 0; mem_to_regM = 0;
      div_startE = 0; div_doneE = 0; i_stall = 0; d_stall = 0;
      exceptionM = 0; mispredictE = 0;
   endtask

   // Called at a negedge with inputs applied: check outputs, then advance the model one edge.
   task automatic tick(input string tag);
      int         row;
      bit         g, e, divHold;
      bit         nBusy, nExc, nMp;
      logic [10:0] exp;
      #1;
      g       = i_stall || d_stall;
      e       = exceptionM || mExcOwed;
      divHold = mBusy ? !div_doneE : div_startE;
      if (e && !g)                       row = 1;
      else if (g)                        row = 2;
      else if (divHold)                  row = 3;
      else if (luRef())                  row = 4;
      else if (mispredictE || mMpOwed)   row = 5;
      else                               row = 0;
      case (row)
         1:       exp = {5'b00000, 4'b1111, (mBusy || div_startE), mBusy};
         2:       exp = {5'b11111, 4'b0000, 1'b0, mBusy};
         3:       exp = {5'b11100, 4'b0010, 1'b0, mBusy};
         4:       exp = {5'b11000, 4'b0100, 1'b0, mBusy};
         5:       exp = {5'b00000, 4'b1000, 1'b0, mBusy};
         default: exp = {10'b0, mBusy};
      endcase
      checkVal(tag, {21'd0, obs()}, {21'd0, exp});
      nBusy = mBusy; nExc = mExcOwed; nMp = mMpOwed;
      case (row)
         1: begin nBusy = 0; nExc = 0; nMp = 0; end
         2: begin
            nExc = mExcOwed || exceptionM;
            nMp  = mMpOwed || mispredictE;
            if (mBusy && div_doneE) nBusy = 0;
         end
         3: begin nBusy = 1; nMp = mMpOwed || mispredictE; end
         4: begin nBusy = 0; nMp = mMpOwed || mispredictE; end
         5: begin nBusy = 0; nMp = 0; end
         default: nBusy = 0;
      endcase
      @(posedge clk);
      mBusy = nBusy; mExcOwed = nExc; mMpOwed = nMp;
      @(negedge clk);
   endtask

   initial begin
      int sE, fM, bz;
      rst = 1'b0;
      clearInputs();
      mBusy = 0; mExcOwed = 0; mMpOwed = 0;
      #1;
      checkVal("reset_outs", {21'd0, obs()}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Load-use on rs via E, then the same producer writing $0.
      clearInputs();
      mem_to_regE = 1; reg_write_enE = 1; write_regE = 5; rsD = 5;
      #1 checkVal("lu_hit", {stallF, stallD, flushE}, 3'b111);
      tick("lu_hit_model");
      write_regE = 0;
      #1 checkVal("lu_r0", {stallF, stallD, flushE}, 3'b000);
      tick("lu_r0_model");

      // Divide: start at t, done at t+35.
      clearInputs();
      sE = 0; fM = 0; bz = 0;
      for (int c = 0; c < 35; c++) begin
         div_startE = (c == 0);
         #1;
         sE += int'(stallE); fM += int'(flushM); bz += int'(div_busy);
         tick("div_wait");
      end
      checkVal("div_stallE_cycles", sE, 35);
      checkVal("div_flushM_cycles", fM, 35);
      checkVal("div_busy_cycles", bz, 34);
      div_doneE = 1;
      #1 checkVal("div_done_nostall", {stallE, div_busy}, 2'b01);
      tick("div_done");
      div_doneE = 0;
      #1 checkVal("div_back_run", div_busy, 0);
      tick("div_run");

      // Exception while the divider is busy.
      clearInputs();
      div_startE = 1; tick("exdiv_start");
      div_startE = 0; repeat (5) tick("exdiv_wait");
      exceptionM = 1;
      #1 checkVal("exdiv_cancel", {div_cancel, flushD, flushE, flushM, flushW}, 5'b11111);
      tick("exdiv_exc");
      exceptionM = 0;
      #1 checkVal("exdiv_after", {div_busy, stallE, div_cancel}, 3'b000);
      tick("exdiv_after_model");

      // Exception arriving under a data-cache stall is deferred to the first free cycle.
      clearInputs();
      for (int t = 3; t <= 8; t++) begin
         d_stall = 1; exceptionM = (t == 4);
         #1 checkVal("exstall_hold", {stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, flushW}, 9'h1f0);
         tick("exstall_model");
      end
      clearInputs();
      #1 checkVal("exstall_flush", {flushD, flushE, flushM, flushW}, 4'hf);
      tick("exstall_flush_model");
      #1 checkVal("exstall_once", {flushD, flushE, flushM, flushW}, 4'h0);
      tick("exstall_once_model");

      // Mispredict coinciding with a load-use stall is replayed next cycle.
      clearInputs();
      mem_to_regM = 1; write_regM = 7; rtD = 7; mispredictE = 1;
      #1 checkVal("mplu_first", {flushD, stallD}, 2'b01);
      tick("mplu_first_model");
      clearInputs();
      #1 checkVal("mplu_replay", flushD, 1);
      tick("mplu_replay_model");
      #1 checkVal("mplu_done", flushD, 0);
      tick("mplu_done_model");

      // Asynchronous reset mid-divide with an exception owed.
      clearInputs();
      div_startE = 1; tick("ar_start");
      div_startE = 0; d_stall = 1; exceptionM = 1; tick("ar_pend");
      exceptionM = 0; tick("ar_hold");
      clearInputs();
      #2 rst = 1'b0;
      #1 checkVal("ar_async_outs", {21'd0, obs()}, 32'd0);
      mBusy = 0; mExcOwed = 0; mMpOwed = 0;
      @(negedge clk);
      rst = 1'b1;
      tick("ar_released");

      // Randomized traffic with small register numbers to provoke matches.
      for (int c = 0; c < 3000; c++) begin
         rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
         write_regE = 5'($urandom_range(0, 3)); write_regM = 5'($urandom_range(0, 3));
         mem_to_regE   = ($urandom_range(0, 3) == 0);
         reg_write_enE = ($urandom_range(0, 1) == 0);
         mem_to_regM   = ($urandom_range(0, 3) == 0);
         i_stall       = ($urandom_range(0, 7) == 0);
         d_stall       = ($urandom_range(0, 7) == 0);
         exceptionM    = ($urandom_range(0, 15) == 0);
         mispredictE   = ($urandom_range(0, 5) == 0);
         div_startE    = ($urandom_range(0, 9) == 0);
         div_doneE     = mBusy && ($urandom_range(0, 7) == 0);
         tick("rand");
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall/flush scheduler for the five-stage MIPS core. It generates the per-stage `stallX`/`flushX` controls consumed by the F/D, D/E (`id_ex`), E/M and M/W pipeline registers. It arbitrates between cache-miss stalls, the multi-cycle divider, load-use hazards, M-stage exceptions and E-stage branch mispredicts. Flushes that arrive during a global stall are held pending and applied in the first cycle the stall drops.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous, active-low reset.
- `rsD`, `rtD`  in  5 each  source registers of the instruction in D.
- `mem_to_regE`, `reg_write_enE`  in  1 each  instruction in E is a load / writes the register file.
- `write_regE`  in  5  destination register of the instruction in E.
- `mem_to_regM`  in  1  instruction in M is a load.
- `write_regM`  in  5  destination register of the instruction in M.
- `div_startE`  in  1  divide in E requests start.
- `div_doneE`  in  1  divider result valid; single-cycle pulse.
- `i_stall`, `d_stall`  in  1 each  I-cache / D-cache miss in progress.
- `exceptionM`  in  1  exception or eret committed in M.
- `mispredictE`  in  1  branch in E resolved against its prediction.
- `stallF`, `stallD`, `stallE`, `stallM`, `stallW`  out  1 each  hold the corresponding pipeline register.
- `flushD`, `flushE`, `flushM`, `flushW`  out  1 each  clear the corresponding pipeline register.
- `div_cancel`  out  1  abort the divider.
- `div_busy`  out  1  high when `state==DIV_WAIT`.

## Operation
- Internal state:
  - `state` ∈ {RUN, DIV_WAIT}.
  - `exc_pend` and `mp_pend` flags.
- Derived terms:
  - gstall = `i_stall | d_stall`.
  - exc = `exceptionM | exc_pend`.
  - lu = (`mem_to_regE & reg_write_enE & write_regE!=0` & `write_regE`∈{`rsD`,`rtD`}) | (`mem_to_regM & write_regM!=0` & `write_regM`∈{`rsD`,`rtD`}).
  - dstall = (RUN & `div_startE`) | (DIV_WAIT & ~`div_doneE`).
- Strict priority; exactly one row applies per cycle, and any output not named is 0:
  1. exc & ~gstall:
     - `flushD`, `flushE`, `flushM`, `flushW` = 1.
     - `div_cancel` = (state==DIV_WAIT) | `div_startE`.
     - Next: state←RUN, `exc_pend`←0, `mp_pend`←0.
  2. gstall:
     - All five stalls = 1.
     - `exceptionM` sets `exc_pend`.
     - `mispredictE` sets `mp_pend`.
     - state does not advance, except that `div_doneE` in DIV_WAIT still moves it to RUN.
  3. dstall:
     - `stallF`, `stallD`, `stallE` = 1 and `flushM` = 1 (bubble into M).
     - RUN & `div_startE` → DIV_WAIT.
  4. lu: `stallF`, `stallD` = 1 and `flushE` = 1.
  5. `mispredictE | mp_pend`: `flushD` = 1, `mp_pend`←0.
- Interactions:
  - If `mispredictE` coincides with row 3 or row 4, `mp_pend` is set.
  - DIV_WAIT & `div_doneE` & no higher row → state←RUN. No stall in that cycle; the result proceeds to M.
- Outputs are combinational from state, pending flags and inputs. `div_busy` = (state==DIV_WAIT).

## Timing
- Reset (`rst`=0, asynchronous): state=RUN, `exc_pend`=`mp_pend`=0. With all inputs 0, every output is 0.
- Zero-cycle latency: stall and flush outputs respond in the same cycle as their causing inputs.
- Pending flush: applied in the first cycle gstall is low, i.e. the edge after gstall falls, at the earliest. It is applied exactly once.
- Divide: `div_startE` at cycle t and `div_doneE` at cycle t+N give stallE high for cycles t..t+N-1 and low at t+N.
- `exceptionM` during DIV_WAIT: `div_cancel` pulses for 1 cycle and the FSM is in RUN the next cycle.
- `div_doneE` together with `exceptionM`: the exception wins; `div_cancel`=1 and the result is discarded via `flushM`.
- Deasserting reset mid-divide leaves the FSM in RUN. The divider is reset by the same `rst`.

## Structure
- A shared `pipe_pkg` holds:
  - the `ctrl_state_t` enum (RUN, DIV_WAIT);
  - the stage-index constants used by the stall/flush vectors.
- Natural sub-module: `hazard_detect`, the combinational lu compare for the E and M stages. The FSM and priority logic stay in `pipe_ctrl`.

## Test plan
- Load-use hazard: `mem_to_regE`=`reg_write_enE`=1, `write_regE`=5, `rsD`=5 → one cycle of `stallF`=`stallD`=`flushE`=1. With `write_regE`=0 → no stall.
- Divide: `div_startE` at t=10, `div_doneE` at t=45 → `stallE` high for t=10..44, `flushM` high for the same cycles, `div_busy` high for t=11..45, RUN at t=46.
- Exception during `d_stall`: `d_stall` high for t=3..8, `exceptionM` at t=4 → all stalls high for t=3..8, then all flushes high at t=9 only, `exc_pend`=0 at t=10.
- Exception during divide: `exceptionM` at t=20 in DIV_WAIT → `div_cancel`=1 and flushes D..W at t=20, `div_busy`=0 at t=21, no stall at t=21.
- Mispredict under load-use: `mispredictE` together with lu at t=7 → `flushD`=0 at t=7, `flushD`=1 at t=8, then 0.
- Asynchronous reset mid-DIV_WAIT with `exc_pend` set → `div_busy`=0 and all outputs 0 immediately, with no clock edge required.
